// File: rtl/jrb8_pkg.sv
// rtl/jrb8_pkg.sv - shared types and constants for the jrb8 serial memory bridge
package jrb8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        DONE
    } state_t;

    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 8;

    localparam logic SPACE_ROM = 1'b0;
    localparam logic SPACE_RAM = 1'b1;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchroniser
// Ports: clk, rst_n (async active-low), d (asynchronous input), q (synchronised output)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_mem_bridge.sv
// rtl/serial_mem_bridge.sv - bit-serial ROM/RAM master for jrb8 fetch/load/store
// Ports: clk, rst_n (async active-low)
//        req_valid/req_ready/req_write/req_space/req_addr/req_wdata : core request
//        resp_valid/resp_rdata/resp_err                           : completion
//        sclk_out/serial_out/serial_in/ext_ready                  : host pins
//        pc_in_flag/rom_out_flag/ram_in_flag/ram_out_flag         : status flags
module serial_mem_bridge
    import jrb8_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_space,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 sclk_out,
    output logic                 serial_out,
    input  logic                 serial_in,
    input  logic                 ext_ready,
    output logic                 pc_in_flag,
    output logic                 rom_out_flag,
    output logic                 ram_in_flag,
    output logic                 ram_out_flag
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    state_t               state;
    logic [ADDR_BITS-1:0] tx_sh;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 write_q;
    logic [4:0]           bit_cnt;
    logic [PW-1:0]        phase_cnt;
    logic [SW-1:0]        stall_cnt;
    logic                 ready_s;
    logic                 sin_s;
    logic                 last_bit;

    sync2 u_sync_ready (.clk(clk), .rst_n(rst_n), .d(ext_ready), .q(ready_s));
    sync2 u_sync_sin   (.clk(clk), .rst_n(rst_n), .d(serial_in), .q(sin_s));

    always_comb begin
        last_bit = 1'b0;
        if (state == ADDR) last_bit = (bit_cnt == 5'(ADDR_BITS - 1));
        else               last_bit = (bit_cnt == 5'(DATA_BITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tx_sh        <= '0;
            wdata_q      <= '0;
            rx_sh        <= '0;
            write_q      <= 1'b0;
            bit_cnt      <= '0;
            phase_cnt    <= '0;
            stall_cnt    <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            sclk_out     <= 1'b0;
            serial_out   <= 1'b0;
            pc_in_flag   <= 1'b0;
            rom_out_flag <= 1'b0;
            ram_in_flag  <= 1'b0;
            ram_out_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        if (req_space == SPACE_ROM && req_write) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            // First address bit goes out with the first low-phase cycle.
                            state        <= ADDR;
                            serial_out   <= req_addr[ADDR_BITS-1];
                            tx_sh        <= {req_addr[ADDR_BITS-2:0], 1'b0};
                            bit_cnt      <= '0;
                            phase_cnt    <= '0;
                            stall_cnt    <= '0;
                            pc_in_flag   <= 1'b1;
                            rom_out_flag <= (req_space == SPACE_ROM);
                            ram_in_flag  <= (req_space == SPACE_RAM) && req_write;
                            ram_out_flag <= (req_space == SPACE_RAM) && !req_write;
                        end
                    end
                end

                ADDR, WDATA, RDATA: begin
                    if (!sclk_out) begin
                        if (phase_cnt != PH_LAST) begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end else if (ready_s) begin
                            sclk_out  <= 1'b1;
                            phase_cnt <= '0;
                            stall_cnt <= '0;
                            if (state == RDATA) rx_sh <= {rx_sh[DATA_BITS-2:0], sin_s};
                        end else if (stall_cnt == STALL_LAST) begin
                            // Host never became ready: abandon the transfer.
                            state        <= DONE;
                            resp_valid   <= 1'b1;
                            resp_err     <= 1'b1;
                            serial_out   <= 1'b0;
                            pc_in_flag   <= 1'b0;
                            rom_out_flag <= 1'b0;
                            ram_in_flag  <= 1'b0;
                            ram_out_flag <= 1'b0;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else if (phase_cnt != PH_LAST) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end else begin
                        // End of a bit: fall and present the next bit in the same edge.
                        sclk_out  <= 1'b0;
                        phase_cnt <= '0;
                        if (!last_bit) begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            serial_out <= (state == RDATA) ? 1'b0 : tx_sh[ADDR_BITS-1];
                            tx_sh      <= {tx_sh[ADDR_BITS-2:0], 1'b0};
                        end else if (state == ADDR) begin
                            bit_cnt    <= '0;
                            pc_in_flag <= 1'b0;
                            if (write_q) begin
                                state      <= WDATA;
                                serial_out <= wdata_q[DATA_BITS-1];
                                tx_sh      <= {wdata_q[DATA_BITS-2:0], {(ADDR_BITS-DATA_BITS+1){1'b0}}};
                            end else begin
                                state      <= RDATA;
                                serial_out <= 1'b0;
                            end
                        end else begin
                            state        <= DONE;
                            resp_valid   <= 1'b1;
                            resp_err     <= 1'b0;
                            serial_out   <= 1'b0;
                            rom_out_flag <= 1'b0;
                            ram_in_flag  <= 1'b0;
                            ram_out_flag <= 1'b0;
                            if (state == RDATA) resp_rdata <= rx_sh;
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_mem_bridge.md
Name: serial_mem_bridge

Overview:
- Bit-serial memory master between the jrb8 core's fetch/load/store requests and the off-chip ROM/RAM host on the TinyTapeout pins.
- Replaces ad-hoc per-bit shifting in the top level with one handshaked, clk-driven engine.
- Generates sclk, shifts a 16-bit address MSB-first, then shifts 8 data bits out (RAM write) or in (ROM/RAM read).
- Honours the host's ready line and drives the pc_in/rom_out/ram_in/ram_out status flags on uo_out.

Parameters:
- CLK_DIV, 2: clk cycles per sclk half-period (>=1).
- TIMEOUT, 1024: max consecutive stalled clk cycles before abort (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  bridge idle, request accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_space  in  1  0=ROM, 1=RAM
- req_addr  in  16  byte address
- req_wdata  in  8  write data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  8  read data, valid with resp_valid, held until next accept
- resp_err  out  1  with resp_valid: timeout or illegal ROM write
- sclk_out  out  1  serial clock to host
- serial_out  out  1  address/write-data bit to host
- serial_in  in  1  read-data bit from host (async)
- ext_ready  in  1  host ready (async)
- pc_in_flag  out  1  high during address phase
- rom_out_flag  out  1  high for whole ROM read
- ram_in_flag  out  1  high for whole RAM write
- ram_out_flag  out  1  high for whole RAM read

Behaviour:
- Reset (async): state IDLE, all outputs 0 except req_ready=1; shift regs, counters, synchronisers cleared. Reset mid-transfer aborts immediately: sclk_out=0, no resp_valid.
- ext_ready and serial_in each pass a 2-flop synchroniser (reset 0) before use.
- States: IDLE, ADDR, WDATA, RDATA, DONE.
- IDLE: req_ready=1. On accept latch addr/wdata/write/space.
  - ROM write (space=0, write=1): go to DONE with resp_err=1, no pin activity.
  - Otherwise go to ADDR.
- Bit timing: each bit = low phase + high phase, CLK_DIV cycles each.
  - serial_out updated on first cycle of low phase.
  - Low->high transition occurs only if synced ready=1 at end of low phase; else sclk held low (stall) and stall counter increments.
  - Stall counter clears on every completed rise.
  - Stall counter reaching TIMEOUT -> DONE with resp_err=1, flags drop, sclk_out=0.
- Read sampling: RDATA samples synced serial_in on the cycle sclk_out rises; bits shift in MSB-first.
- ADDR: 16 bits, addr[15] first; pc_in_flag=1. After bit 0 high phase go to WDATA (write) or RDATA (read).
- WDATA: 8 bits wdata[7] first.
- RDATA: 8 bits; serial_out held 0.
- Space flags: rom_out/ram_in/ram_out flag asserted from first ADDR cycle through last data high phase; exactly one high, none in IDLE/DONE.
- DONE: one cycle, resp_valid=1, then IDLE. resp_rdata updated only on successful read; writes leave it unchanged.
- Latency without stalls: resp_valid exactly 48*CLK_DIV+1 cycles after accept cycle; +1 per stall cycle.
- Only one outstanding request; req_valid ignored outside IDLE. New request may be accepted the cycle after DONE.
- Counters: bit counter 5 bits, phase counter ceil(log2(CLK_DIV)) bits, stall counter ceil(log2(TIMEOUT+1)) bits; no wrap permitted.

Decomposition:
- Shared package jrb8_pkg: state enum (IDLE, ADDR, WDATA, RDATA, DONE), ADDR_BITS=16, DATA_BITS=8, space encodings SPACE_ROM=0/SPACE_RAM=1.
- One sub-module: sync2, a generic 2-flop synchroniser with async active-low reset, instantiated twice.

Test Plan:
- CLK_DIV=2, ext_ready=1, RAM read addr 16'h1234, host returns 8'hA5 MSB-first on rises -> serial_out carries 0001001000110100 on 16 rises, ram_out_flag high throughout, pc_in_flag for first 16 bits, resp_valid 97 cycles after accept, resp_rdata=A5, resp_err=0.
- RAM write addr 16'h00FF data 8'h3C -> 24 rises, data bits 00111100, ram_in_flag high, resp_valid at +97, resp_rdata unchanged.
- ROM write request -> resp_valid with resp_err=1 within 2 cycles, sclk_out never toggles, no flag asserted.
- ROM read with ext_ready low 10 cycles before bit 5 -> sclk_out held low, resp_valid at +107, rom_out_flag high, data correct.
- TIMEOUT=16, ext_ready stuck low -> resp_valid with resp_err=1 after 16 stall cycles, flags 0, req_ready=1 next cycle.
- Assert rst_n low during RDATA bit 3 -> all outputs reset asynchronously; next request after release completes normally.
